// File: rtl/vseq_pkg.sv
// Shared definitions for the vec_alu_seq strip-mining sequencer: opcodes, FSM encoding, helpers.
package vseq_pkg;

  localparam logic [7:0] OP_VADD_VV   = 8'h00;
  localparam logic [7:0] OP_VMUL_VV   = 8'h01;
  localparam logic [7:0] OP_VDOT_VV   = 8'h02;
  localparam logic [7:0] OP_VADD_VARP = 8'h03;
  localparam logic [7:0] OP_VMUL_VARP = 8'h04;
  localparam logic [7:0] OP_VDOT_VARP = 8'h05;
  localparam logic [7:0] OP_NOP       = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_CAP  = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4,
    S_FIN  = 3'd5
  } state_e;

  // Dot-product ops are the only ones that consume the accumulator operand.
  function automatic logic is_dot(input logic [7:0] op);
    return (op == OP_VDOT_VV) || (op == OP_VDOT_VARP);
  endfunction

  function automatic logic is_legal_op(input logic [7:0] op);
    return (op >= OP_VADD_VV) && (op <= OP_VDOT_VARP);
  endfunction

endpackage

// File: rtl/vseq_if.sv
// Request handshake between vector decode (master) and the vec_alu_seq sequencer (slave).
interface vseq_if #(
  parameter int REG_W   = 5,
  parameter int CHUNK_W = 2
);

  logic               req_valid;
  logic               req_ready;
  logic [7:0]         req_op;
  logic [9:0]         req_sew;
  logic [3:0]         req_vap;
  logic [REG_W-1:0]   req_vd;
  logic [REG_W-1:0]   req_vs1;
  logic [REG_W-1:0]   req_vs2;
  logic [REG_W-1:0]   req_vs3;
  logic [CHUNK_W:0]   req_nchunks;

  modport master (
    output req_valid, req_op, req_sew, req_vap,
           req_vd, req_vs1, req_vs2, req_vs3, req_nchunks,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_op, req_sew, req_vap,
           req_vd, req_vs1, req_vs2, req_vs3, req_nchunks,
    output req_ready
  );

endinterface

// File: rtl/vseq_addr_gen.sv
// Forms {register, chunk} register-file addresses from the latched request and the chunk counter.
module vseq_addr_gen
  import vseq_pkg::*;
#(
  parameter int REG_W   = 5,
  parameter int CHUNK_W = 2
) (
  input  logic [REG_W-1:0]         vd_i,
  input  logic [REG_W-1:0]         vs1_i,
  input  logic [REG_W-1:0]         vs2_i,
  input  logic [REG_W-1:0]         vs3_i,
  input  logic [CHUNK_W-1:0]       chunk_i,
  output logic [REG_W+CHUNK_W-1:0] raddr_a_o,
  output logic [REG_W+CHUNK_W-1:0] raddr_b_o,
  output logic [REG_W+CHUNK_W-1:0] raddr_c_o,
  output logic [REG_W+CHUNK_W-1:0] waddr_o
);

  assign raddr_a_o = {vs1_i, chunk_i};
  assign raddr_b_o = {vs2_i, chunk_i};
  assign raddr_c_o = {vs3_i, chunk_i};
  assign waddr_o   = {vd_i,  chunk_i};

endmodule

// File: rtl/vec_alu_seq.sv
// Strip-mining sequencer for alu_block: READ -> CAP -> EXEC -> WB per 128-bit chunk.
// Optional alu_done watchdog enabled by defining VSEQ_TIMEOUT_EN.
module vec_alu_seq
  import vseq_pkg::*;
#(
  parameter int DATA_W  = 128,
  parameter int REG_W   = 5,
  parameter int CHUNK_W = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     resetn,
  vseq_if.slave                    req,
  output logic                     rf_ren_o,
  output logic [REG_W+CHUNK_W-1:0] rf_raddr_a_o,
  output logic [REG_W+CHUNK_W-1:0] rf_raddr_b_o,
  output logic [REG_W+CHUNK_W-1:0] rf_raddr_c_o,
  input  logic [DATA_W-1:0]        rf_rdata_a_i,
  input  logic [DATA_W-1:0]        rf_rdata_b_i,
  input  logic [DATA_W-1:0]        rf_rdata_c_i,
  output logic                     rf_wen_o,
  output logic [REG_W+CHUNK_W-1:0] rf_waddr_o,
  output logic [DATA_W-1:0]        rf_wdata_o,
  output logic [7:0]               alu_instr_o,
  output logic [9:0]               alu_sew_o,
  output logic [3:0]               alu_vap_o,
  output logic [DATA_W-1:0]        alu_opA_o,
  output logic [DATA_W-1:0]        alu_opB_o,
  output logic [DATA_W-1:0]        alu_opC_o,
  input  logic [DATA_W-1:0]        alu_out_i,
  input  logic                     alu_done_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  localparam logic [CHUNK_W:0] MAX_CHUNKS = (CHUNK_W+1)'(2**CHUNK_W);

  state_e             state_q, state_d;
  logic [7:0]         op_q, op_d;
  logic [9:0]         sew_q, sew_d;
  logic [3:0]         vap_q, vap_d;
  logic [REG_W-1:0]   vd_q, vd_d, vs1_q, vs1_d, vs2_q, vs2_d, vs3_q, vs3_d;
  logic [CHUNK_W:0]   nchunks_q, nchunks_d;
  logic [CHUNK_W-1:0] chunk_q, chunk_d;
  logic               errFlag_q, errFlag_d;
  logic [DATA_W-1:0]  opA_q, opA_d, opB_q, opB_d, opC_q, opC_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               lastChunk;

`ifdef VSEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT) + 1;
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  assign lastChunk = ({1'b0, chunk_q} == (nchunks_q - 1'b1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      sew_q     <= '0;
      vap_q     <= '0;
      vd_q      <= '0;
      vs1_q     <= '0;
      vs2_q     <= '0;
      vs3_q     <= '0;
      nchunks_q <= '0;
      chunk_q   <= '0;
      errFlag_q <= 1'b0;
      opA_q     <= '0;
      opB_q     <= '0;
      opC_q     <= '0;
      wdata_q   <= '0;
`ifdef VSEQ_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      sew_q     <= sew_d;
      vap_q     <= vap_d;
      vd_q      <= vd_d;
      vs1_q     <= vs1_d;
      vs2_q     <= vs2_d;
      vs3_q     <= vs3_d;
      nchunks_q <= nchunks_d;
      chunk_q   <= chunk_d;
      errFlag_q <= errFlag_d;
      opA_q     <= opA_d;
      opB_q     <= opB_d;
      opC_q     <= opC_d;
      wdata_q   <= wdata_d;
`ifdef VSEQ_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sew_d     = sew_q;
    vap_d     = vap_q;
    vd_d      = vd_q;
    vs1_d     = vs1_q;
    vs2_d     = vs2_q;
    vs3_d     = vs3_q;
    nchunks_d = nchunks_q;
    chunk_d   = chunk_q;
    errFlag_d = errFlag_q;
    opA_d     = opA_q;
    opB_d     = opB_q;
    opC_d     = opC_q;
    wdata_d   = wdata_q;
`ifdef VSEQ_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req.req_valid) begin
          op_d      = req.req_op;
          sew_d     = req.req_sew;
          vap_d     = req.req_vap;
          vd_d      = req.req_vd;
          vs1_d     = req.req_vs1;
          vs2_d     = req.req_vs2;
          vs3_d     = req.req_vs3;
          chunk_d   = '0;
          errFlag_d = 1'b0;
          // Oversized counts are clamped so the chunk counter can never wrap.
          nchunks_d = (req.req_nchunks > MAX_CHUNKS) ? MAX_CHUNKS : req.req_nchunks;
          if (!is_legal_op(req.req_op)) begin
            errFlag_d = 1'b1;
            state_d   = S_FIN;
          end else if (req.req_nchunks == '0) begin
            state_d   = S_FIN;
          end else begin
            state_d   = S_READ;
          end
        end
      end
      S_READ: state_d = S_CAP;
      S_CAP: begin
        opA_d   = rf_rdata_a_i;
        opB_d   = rf_rdata_b_i;
        opC_d   = is_dot(op_q) ? rf_rdata_c_i : '0;
`ifdef VSEQ_TIMEOUT_EN
        tmo_d   = '0;
`endif
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (alu_done_i) begin
          wdata_d = alu_out_i;
          state_d = S_WB;
`ifdef VSEQ_TIMEOUT_EN
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          errFlag_d = 1'b1;
          state_d   = S_FIN;
        end else begin
          tmo_d = tmo_q + 1'b1;
`endif
        end
      end
      S_WB: begin
        if (lastChunk) begin
          state_d = S_FIN;
        end else begin
          chunk_d = chunk_q + 1'b1;
          state_d = S_READ;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  vseq_addr_gen #(
    .REG_W   (REG_W),
    .CHUNK_W (CHUNK_W)
  ) u_addr_gen (
    .vd_i      (vd_q),
    .vs1_i     (vs1_q),
    .vs2_i     (vs2_q),
    .vs3_i     (vs3_q),
    .chunk_i   (chunk_q),
    .raddr_a_o (rf_raddr_a_o),
    .raddr_b_o (rf_raddr_b_o),
    .raddr_c_o (rf_raddr_c_o),
    .waddr_o   (rf_waddr_o)
  );

  // Outputs decode straight from the state register so they are glitch-free.
  assign req.req_ready = (state_q == S_IDLE);
  assign rf_ren_o      = (state_q == S_READ);
  assign rf_wen_o      = (state_q == S_WB);
  assign rf_wdata_o    = wdata_q;
  assign alu_instr_o   = (state_q == S_EXEC) ? op_q : OP_NOP;
  assign alu_sew_o     = sew_q;
  assign alu_vap_o     = vap_q;
  assign alu_opA_o     = opA_q;
  assign alu_opB_o     = opB_q;
  assign alu_opC_o     = opC_q;
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_FIN);
  assign err_o         = (state_q == S_FIN) && errFlag_q;

endmodule
